acc_readout: RTL and testbench

- Histogram readout engine: the read side of the landscape-sampling accumulator memory, which the accumulator fills by read-modify-write.
- On a start pulse, sweeps bins 0..bin_last of the accumulator RAM (synchronous read, 1-cycle latency) and streams each count out with a valid/ready handshake.
- Optionally writes zero back to each bin after it is read.
- Asserts busy for the whole sweep; upstream uses busy to stall the accumulator writer, so this block owns the RAM port while busy=1.

---
 rtl/acc_readout.sv | 137 +++++++++++++
 tb/tb_acc_readout.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_readout.sv
// Histogram readout engine: sweeps accumulator bins 0..bin_last, streams each
// count over valid/ready, and optionally zeroes each bin once it has been read.
module acc_readout #(
  parameter int bit_addr_acc = 19,
  parameter int bit_addr_bin = 10
) (
  input  logic                                 clk,
  input  logic                                 clr_n,
  input  logic                                 start,
  input  logic                                 clear_after_read,
  input  logic [bit_addr_bin-1:0]              bin_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 mem_rd_en,
  output logic [bit_addr_bin-1:0]              mem_rd_addr,
  input  logic [bit_addr_acc-1:0]              mem_rd_data,
  output logic                                 mem_wr_en,
  output logic [bit_addr_bin-1:0]              mem_wr_addr,
  output logic [bit_addr_acc-1:0]              mem_wr_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [bit_addr_bin-1:0]              out_addr,
  output logic [bit_addr_acc-1:0]              out_data,
  output logic                                 out_last,
  output logic [bit_addr_acc+bit_addr_bin-1:0] sum
);

  localparam int W_SUM = bit_addr_acc + bit_addr_bin;
  localparam logic [bit_addr_bin-1:0] ADDR_ONE = {{(bit_addr_bin-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_PRESENT, S_FIN} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [bit_addr_bin-1:0]   r_bin_last;
  logic                      r_clr;
  logic [bit_addr_bin-1:0]   r_addr;
  logic [W_SUM-1:0]          r_sum;
  logic                      r_out_valid;
  logic [bit_addr_bin-1:0]   r_out_addr;
  logic [bit_addr_acc-1:0]   r_out_data;
  logic                      r_out_last;
  logic                      w_start;
  logic                      w_accept;
  logic [W_SUM-1:0]          w_rd_ext;

  assign w_start  = (r_state == S_IDLE) && start;
  assign w_accept = (r_state == S_PRESENT) && r_out_valid && out_ready;
  assign w_rd_ext = {{bit_addr_bin{1'b0}}, mem_rd_data};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // RAM strobes are decoded from state so an asynchronous reset kills them at once.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_READ;
      end
      S_READ: begin
        busy         = 1'b1;
        mem_rd_en    = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        busy         = 1'b1;
        mem_wr_en    = r_clr;
        w_state_next = S_PRESENT;
      end
      S_PRESENT: begin
        busy = 1'b1;
        if (w_accept) w_state_next = r_out_last ? S_FIN : S_READ;
      end
      S_FIN: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_bin_last  <= '0;
      r_clr       <= 1'b0;
      r_addr      <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_start) begin
        r_bin_last <= bin_last;
        r_clr      <= clear_after_read;
        r_addr     <= '0;
        r_sum      <= '0;
      end
      if (r_state == S_WAIT) begin
        r_out_data  <= mem_rd_data;
        r_out_addr  <= r_addr;
        r_out_last  <= (r_addr == r_bin_last);
        r_out_valid <= 1'b1;
        r_sum       <= r_sum + w_rd_ext;
      end
      // The final bin never increments, so the counter cannot wrap at full scale.
      if (w_accept) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        if (!r_out_last) r_addr <= r_addr + ADDR_ONE;
      end
    end
  end

  assign mem_rd_addr = r_addr;
  assign mem_wr_addr = r_addr;
  assign mem_wr_data = '0;
  assign out_valid   = r_out_valid;
  assign out_addr    = r_out_addr;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign sum         = r_sum;

endmodule

// File: tb/tb_acc_readout.sv
// Randomized bench for acc_readout: behavioural RAM plus a bin-array reference
// model predicting the beat stream, sum, clear writes and final RAM contents.
module tb_acc_readout;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b1;
  logic        clear_after_read = 1'b0;
  logic [9:0]  bin_last = '0;
  logic        busy, done, mem_rd_en, mem_wr_en, out_valid, out_last;
  logic [9:0]  mem_rd_addr, mem_wr_addr, out_addr;
  logic [18:0] mem_rd_data = '0;
  logic [18:0] mem_wr_data, out_data;
  logic        out_ready = 1'b1;
  logic [28:0] sum;

  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [18:0] ld_data = '0;
  logic [18:0] ram [0:1023] = '{default: '0};

  int unsigned exp_mem [1024];
  int n_checks = 0;
  int n_fail = 0;
  int bp_mode = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  acc_readout #(.bit_addr_acc(19), .bit_addr_bin(10)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .clear_after_read(clear_after_read),
    .bin_last(bin_last), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_last(out_last), .sum(sum)
  );

  // Accumulator RAM: synchronous read, one-cycle latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    if (ld_en) ram[ld_addr] <= ld_data;
  end

  // Consumer: 0 always ready, 1 stalls bin 1 for 5 cycles then random, 2 blocks bin 2.
  always @(posedge clk) begin
    #1;
    if (!busy) stall_cnt = 0;
    case (bp_mode)
      1: begin
        if (out_valid && out_addr == 10'd1 && stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt = stall_cnt + 1;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      2: out_ready = !(out_valid && out_addr == 10'd2);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input int unsigned d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = 10'(a);
    ld_data = 19'(d);
    exp_mem[a] = d;
  endtask

  task automatic load_end();
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  function automatic int ram_mismatches();
    int m = 0;
    for (int k = 0; k < 1024; k++)
      if (ram[k] !== 19'(exp_mem[k])) m++;
    return m;
  endfunction

  task automatic sweep(input int bl, input bit clr, input int bp, input bit restart, input string tag);
    int n = bl + 1;
    int cyc = 0, nbusy = 0, bad_rd = 0, unstable = 0, idle_mem = 0, bad_wr = 0;
    logic [9:0]  qa[$];
    logic [18:0] qd[$];
    logic        ql[$];
    logic [9:0]  wa[$];
    logic [18:0] wd[$];
    logic        prev_stall = 1'b0;
    logic [9:0]  pa = '0;
    logic [18:0] pd = '0;
    longint      exp_sum = 0;
    bit          got_done = 1'b0;
    bp_mode = bp;
    @(negedge clk);
    bin_last = 10'(bl);
    clear_after_read = clr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin_last = 10'($urandom);
    clear_after_read = 1'($urandom);
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    while (cyc < 8 * n + 100) begin
      cyc++;
      if (busy) nbusy++;
      if (!busy && (mem_rd_en || mem_wr_en)) idle_mem++;
      if (prev_stall && !(out_valid && out_addr == pa && out_data == pd)) unstable++;
      if (out_valid && out_ready) begin
        qa.push_back(out_addr);
        qd.push_back(out_data);
        ql.push_back(out_last);
      end
      if (mem_wr_en) begin
        wa.push_back(mem_wr_addr);
        wd.push_back(mem_wr_data);
      end
      if (mem_rd_en && out_valid) bad_rd++;
      prev_stall = out_valid && !out_ready;
      pa = out_addr;
      pd = out_data;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      start = restart && (cyc == 5);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got_done), 64'd1);
    for (int k = 0; k < n; k++) exp_sum += longint'(exp_mem[k]);
    check({tag, "_beats"}, 64'(qa.size()), 64'(n));
    for (int i = 0; i < n && i < qa.size(); i++) begin
      check({tag, "_addr"}, 64'(qa[i]), 64'(i));
      check({tag, "_data"}, 64'(qd[i]), 64'(exp_mem[i]));
      check({tag, "_last"}, 64'(ql[i]), 64'(i == bl));
    end
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    if (bp == 0) check({tag, "_busy_cycles"}, 64'(nbusy), 64'(3 * n + 1));
    check({tag, "_writes"}, 64'(wa.size()), clr ? 64'(n) : 64'd0);
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] != 10'(i) || wd[i] != '0) bad_wr++;
    check({tag, "_write_seq"}, 64'(bad_wr), 64'd0);
    check({tag, "_stall_stable"}, 64'(unstable), 64'd0);
    check({tag, "_rd_while_valid"}, 64'(bad_rd), 64'd0);
    check({tag, "_idle_mem"}, 64'(idle_mem), 64'd0);
    if (clr) for (int k = 0; k < n; k++) exp_mem[k] = 0;
    @(negedge clk);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_ram"}, 64'(ram_mismatches()), 64'd0);
    $display("sweep %s: bins=%0d clear=%0d sum=%0d beats=%0d busy_cycles=%0d",
             tag, n, clr, exp_sum, qa.size(), nbusy);
  endtask

  initial begin
    int cyc;
    int bl;
    for (int k = 0; k < 1024; k++) exp_mem[k] = 0;

    // Reset held with start asserted.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    start = 1'b0;
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);
    $display("reset: outputs idle");

    load(0, 5); load(1, 0); load(2, 7); load(3, 524287); load_end();
    sweep(3, 1'b0, 0, 1'b0, "basic");
    sweep(3, 1'b1, 0, 1'b0, "clear");
    sweep(3, 1'b0, 0, 1'b0, "after_clear");

    for (int k = 0; k < 8; k++) load(k, $urandom_range(0, 524287));
    load_end();
    sweep(7, 1'b0, 1, 1'b0, "backpressure");

    load(0, $urandom_range(1, 524287)); load_end();
    sweep(0, 1'b0, 0, 1'b0, "single");

    for (int k = 0; k < 1024; k++) load(k, k);
    load_end();
    sweep(1023, 1'b0, 0, 1'b1, "full_restart");

    for (int r = 0; r < 3; r++) begin
      bl = $urandom_range(1, 20);
      for (int k = 0; k <= bl; k++) load(k, $urandom_range(0, 524287));
      load_end();
      sweep(bl, 1'($urandom), 1, 1'b0, "random");
    end

    // Abort a clearing sweep while bin 2 is being presented.
    for (int k = 0; k < 10; k++) load(k, 100 + k);
    load_end();
    bp_mode = 2;
    @(negedge clk);
    bin_last = 10'd9;
    clear_after_read = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_addr == 10'd2) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reach_bin2", 64'(out_valid && out_addr == 10'd2), 64'd1);
    #1 clr_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_wr_en", 64'(mem_wr_en), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    bp_mode = 0;
    for (int k = 0; k < 3; k++) exp_mem[k] = 0;
    @(negedge clk);
    check("abort_ram", 64'(ram_mismatches()), 64'd0);
    $display("abort: reset during bin 2, ram partially cleared");
    sweep(9, 1'b0, 0, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
